// File: rtl/arbitro_sumador_pkg.sv
// arbitro_sumador_pkg: shared FSM encodings and datapath width for the arbitrated adder
package arbitro_sumador_pkg;
  localparam int DATA_W = 8;
  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_t;
endpackage

// File: rtl/Sumador.sv
// Sumador: shared 8-bit adder, carry out discarded
module Sumador
  import arbitro_sumador_pkg::*;
(
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W-1:0] o_sum
);
  assign o_sum = i_a + i_b;
endmodule

// File: rtl/arbitro_sumador.sv
// arbitro_sumador: round-robin arbiter sharing one adder between two requesters
module arbitro_sumador #(
  parameter int DATA_W = arbitro_sumador_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic [DATA_W-1:0] a0,
  input  logic [DATA_W-1:0] b0,
  input  logic              req1,
  input  logic [DATA_W-1:0] a1,
  input  logic [DATA_W-1:0] b1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] result,
  output logic              busy
);
  import arbitro_sumador_pkg::*;
  state_t r_state, w_state_n;
  logic w_win, w_start;
  logic r_last;
  logic [1:0] r_gnt, r_done;
  logic [DATA_W-1:0] r_op_a, r_op_b, r_result, w_sum;
  always_comb begin
    w_win = (req0 && req1) ? ~r_last : req1;
    w_start = (r_state == IDLE) && (req0 || req1);
    w_state_n = w_start ? EXEC : IDLE;
  end
  // r_last is updated at grant time, so during EXEC it names the requester being served
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_last <= 1'b1;
      r_gnt <= 2'b00;
      r_done <= 2'b00;
      r_op_a <= '0;
      r_op_b <= '0;
      r_result <= '0;
    end else begin
      r_state <= w_state_n;
      r_gnt <= w_start ? (w_win ? 2'b10 : 2'b01) : 2'b00;
      r_done <= (r_state == EXEC) ? (r_last ? 2'b10 : 2'b01) : 2'b00;
      if (w_start) begin
        r_last <= w_win;
        r_op_a <= w_win ? a1 : a0;
        r_op_b <= w_win ? b1 : b0;
      end
      if (r_state == EXEC) r_result <= w_sum;
    end
  end
  Sumador u_sumador (
    .i_a  (r_op_a),
    .i_b  (r_op_b),
    .o_sum(w_sum)
  );
  assign gnt0 = r_gnt[0];
  assign gnt1 = r_gnt[1];
  assign done0 = r_done[0];
  assign done1 = r_done[1];
  assign result = r_result;
  assign busy = (r_state == EXEC);
endmodule

// File: tb/tb_arbitro_sumador.sv
// tb_arbitro_sumador: directed vectors checked against a transaction-level model every cycle
module tb_arbitro_sumador;
  logic clk = 1'b0, reset = 1'b1;
  logic req0 = 1'b0, req1 = 1'b0;
  logic [7:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic gnt0, gnt1, done0, done1, busy;
  logic [7:0] result;
  int checks = 0, errors = 0;

  arbitro_sumador #(.DATA_W(8)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .a0(a0), .b0(b0),
    .req1(req1), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: one transaction at a time, served for exactly one cycle after its grant
  bit m_valid = 0, m_inflight = 0;
  int m_last = 1, m_owner = 0, m_opa = 0, m_opb = 0, m_result = 0;
  bit m_g0, m_g1, m_d0, m_d1;
  always @(posedge clk) begin
    if (reset) begin
      m_valid = 1; m_inflight = 0; m_last = 1; m_result = 0;
      m_g0 = 0; m_g1 = 0; m_d0 = 0; m_d1 = 0;
    end else if (m_inflight) begin
      m_inflight = 0;
      m_g0 = 0; m_g1 = 0;
      m_result = (m_opa + m_opb) % 256;
      m_d0 = (m_owner == 0); m_d1 = (m_owner == 1);
    end else begin
      m_d0 = 0; m_d1 = 0; m_g0 = 0; m_g1 = 0;
      if (req0 || req1) begin
        if (req0 && req1) m_owner = (m_last == 0) ? 1 : 0;
        else m_owner = req1 ? 1 : 0;
        m_opa = (m_owner == 1) ? int'(a1) : int'(a0);
        m_opb = (m_owner == 1) ? int'(b1) : int'(b0);
        m_last = m_owner;
        m_inflight = 1;
        m_g0 = (m_owner == 0); m_g1 = (m_owner == 1);
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("gnt0", 8'(gnt0), 8'(m_g0));
      chk("gnt1", 8'(gnt1), 8'(m_g1));
      chk("done0", 8'(done0), 8'(m_d0));
      chk("done1", 8'(done1), 8'(m_d1));
      chk("busy", 8'(busy), 8'(m_inflight));
      chk("result", result, 8'(m_result));
      chk("onehot", 8'((gnt0 && gnt1) || (done0 && done1)), 8'd0);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    tick(); tick();
    chk("rst_busy", 8'(busy), 8'd0);
    chk("rst_result", result, 8'h00);
    chk("rst_done", 8'({done0, done1, gnt0, gnt1}), 8'd0);
    reset = 1'b0;
    // single request
    req0 = 1; a0 = 8'h12; b0 = 8'h34;
    tick();
    chk("single_gnt0", 8'(gnt0), 8'd1);
    chk("single_busy", 8'(busy), 8'd1);
    req0 = 0;
    tick();
    chk("single_done0", 8'(done0), 8'd1);
    chk("single_result", result, 8'h46);
    chk("single_busy_low", 8'(busy), 8'd0);
    tick();
    chk("single_hold", result, 8'h46);
    // overflow wrap
    req1 = 1; a1 = 8'hF0; b1 = 8'h20;
    tick();
    chk("wrap_gnt1", 8'(gnt1), 8'd1);
    req1 = 0;
    tick();
    chk("wrap_done1", 8'(done1), 8'd1);
    chk("wrap_result", result, 8'h10);
    // simultaneous held requests after reset
    reset = 1;
    tick();
    reset = 0;
    req0 = 1; a0 = 8'd1; b0 = 8'd2; req1 = 1; a1 = 8'd3; b1 = 8'd4;
    for (int i = 0; i < 8; i++) begin
      tick();
      case (i % 4)
        0: chk("rr_gnt0", 8'({gnt0, gnt1}), 8'b10);
        1: begin chk("rr_done0", 8'({done0, done1}), 8'b10); chk("rr_res3", result, 8'd3); end
        2: chk("rr_gnt1", 8'({gnt0, gnt1}), 8'b01);
        default: begin chk("rr_done1", 8'({done0, done1}), 8'b01); chk("rr_res7", result, 8'd7); end
      endcase
    end
    req0 = 0; req1 = 0;
    tick();
    // late request during EXEC
    req0 = 1; a0 = 8'd5; b0 = 8'd6;
    tick();
    req0 = 0; req1 = 1; a1 = 8'd7; b1 = 8'd8;
    tick();
    chk("late_done0", 8'(done0), 8'd1);
    chk("late_res", result, 8'h0B);
    chk("late_no_gnt1", 8'(gnt1), 8'd0);
    tick();
    chk("late_gnt1", 8'(gnt1), 8'd1);
    req1 = 0;
    tick();
    chk("late_done1", 8'(done1), 8'd1);
    chk("late_res1", result, 8'h0F);
    // reset mid-operation
    req0 = 1; a0 = 8'd9; b0 = 8'd9;
    tick();
    chk("abort_gnt0", 8'(gnt0), 8'd1);
    reset = 1;
    tick();
    chk("abort_no_done", 8'({done0, done1}), 8'd0);
    chk("abort_result", result, 8'h00);
    chk("abort_busy", 8'(busy), 8'd0);
    reset = 0;
    tick();
    chk("abort_regnt", 8'(gnt0), 8'd1);
    req0 = 0;
    tick();
    chk("abort_res", result, 8'h12);
    // operand change after grant
    req0 = 1; a0 = 8'h10; b0 = 8'h20;
    tick();
    a0 = 8'hFF; req0 = 0;
    tick();
    chk("stable_done0", 8'(done0), 8'd1);
    chk("stable_res", result, 8'h30);
    // lone requester held: granted back-to-back regardless of pointer
    req1 = 1; a1 = 8'd2; b1 = 8'd2;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i % 2 == 0) chk("lone_gnt1", 8'(gnt1), 8'd1);
      else chk("lone_res", result, 8'd4);
    end
    req1 = 0;
    tick(); tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/arbitro_sumador.md
ARBITRO_SUMADOR -- requirements
Module: arbitro_sumador

Interface
REQ-001 Parameter: DATA_W, default 8, operand/result width; SHALL be 8, matching the shared 8-bit adder.
REQ-002 Clocking and reset: one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req0  input  1  requester 0 wants an addition; held high until gnt0 is sampled high.
REQ-006 a0, b0  input  8 each  requester 0 operands; stable while req0 is high.
REQ-007 req1  input  1  requester 1 request; same rules as req0.
REQ-008 a1, b1  input  8 each  requester 1 operands.
REQ-009 gnt0, gnt1  output  1 each  registered one-cycle grant pulse; operands already captured.
REQ-010 done0, done1  output  1 each  registered one-cycle pulse; result is valid for that requester.
REQ-011 result  output  8  registered sum; holds its value until the next completed operation.
REQ-012 busy  output  1  high whenever the state is not IDLE.

Function
REQ-013 FSM states: IDLE, EXEC; the SHALL-level transitions follow.
- IDLE -> EXEC: at an edge where req0 or req1 is high.
- EXEC -> IDLE: unconditionally at the next edge.
REQ-014 On the IDLE -> EXEC edge, the arbiter SHALL:
- select the winner;
- register its a/b into opA/opB;
- assert its gnt for exactly one cycle.
REQ-015 On the EXEC -> IDLE edge, the arbiter SHALL:
- register result = (opA + opB) mod 256;
- assert the winner's done for exactly one cycle.
Carry out is discarded.
REQ-016 Latency SHALL be 2 cycles.
- Request sampled at edge k; gnt high during cycle k..k+1.
- done and result valid during cycle k+1..k+2.
- Maximum throughput is one operation per 2 cycles.
REQ-017 Arbitration SHALL be round-robin with a 1-bit last-winner pointer.
- Both requests high: the requester not equal to last wins.
- Only one request high: that requester wins, regardless of pointer.
REQ-018 The pointer SHALL update to the winner on the IDLE -> EXEC edge only.
REQ-019 req0/req1 SHALL be ignored while in EXEC; a request arriving in EXEC is served no earlier than the following IDLE edge.
REQ-020 At most one of gnt0/gnt1 is high, and at most one of done0/done1 is high, in any cycle.
REQ-021 A requester holding req high after its grant is treated as a new request. It competes under round-robin, with no starvation of the other requester.
REQ-022 Operand changes after the grant edge SHALL NOT affect the in-flight result.

Reset
REQ-023 Reset SHALL force the following on the next edge, overriding all other activity:
- state = IDLE, last = 1 (requester 0 wins the first tie);
- gnt0 = gnt1 = done0 = done1 = 0, busy = 0;
- result = 0, opA = opB = 0.
REQ-024 Reset asserted in EXEC SHALL abort the operation with no done pulse; a request still high after reset deasserts is re-arbitrated normally.

Structure
REQ-025 Constants SHALL live in a shared definitions file: state encodings (IDLE=0, EXEC=1) and DATA_W.
REQ-026 The addition SHALL be performed by one instance of the existing 8-bit adder module Sumador, fed from opA/opB. No other adder is permitted in this block.

Verification
REQ-027 Single request: req0=1, a0=8'h12, b0=8'h34 at edge 0 -> gnt0 in cycle 0-1; done0 and result=8'h46 in cycle 1-2; busy high in cycle 0-1 only.
REQ-028 Overflow wrap: req1=1, a1=8'hF0, b1=8'h20 -> result=8'h10, done1 pulse, no carry flag.
REQ-029 Simultaneous requests after reset, both held continuously, operands 1+2 and 3+4:
- grant order gnt0, gnt1, gnt0, ...
- results 3, 7, 3, ... alternating;
- done0/done1 never overlap.
REQ-030 Late request: req1 rises while in EXEC serving requester 0 -> ignored until IDLE, then granted; done1 follows 2 cycles later.
REQ-031 Reset mid-op: reset high during EXEC -> next cycle has no done pulse, result=0, busy=0; a held req0 is then re-granted.
REQ-032 Operand change after grant: change a0 to 8'hFF in the gnt0 cycle -> result uses the originally captured operands.
